// File: rtl/hci_core_sink_aligner_if.sv
// Handshake bundles for the sink aligner: input HWPE-Stream and TCDM write port.
// master drives the payload, slave answers with the handshake return.

interface hci_core_sink_aligner_stream_if #(
   parameter int unsigned DATA_WIDTH = 64
);
   logic                    valid;
   logic                    ready;
   logic [DATA_WIDTH-1:0]   data;
   logic [DATA_WIDTH/8-1:0] strb;

   modport master (
      output valid, data, strb,
      input  ready
   );

   modport slave (
      input  valid, data, strb,
      output ready
   );
endinterface

interface hci_core_sink_aligner_tcdm_if #(
   parameter int unsigned DATA_WIDTH = 64
);
   logic                    req;
   logic                    gnt;
   logic [31:0]             add;
   logic                    wen;
   logic [DATA_WIDTH/8-1:0] be;
   logic [DATA_WIDTH-1:0]   data;

   modport master (
      output req, add, wen, be, data,
      input  gnt
   );

   modport slave (
      input  req, add, wen, be, data,
      output gnt
   );
endinterface

// File: rtl/hci_core_sink_aligner.sv
// Stream-to-TCDM writer: stores beat i at base + i*stride, shifting the payload and
// byte enables inside the word to honour byte-misaligned addresses.

module hci_core_sink_aligner #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned TRANS_CNT  = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clear_i,
   input  logic                 enable_i,
   input  logic                 start_i,
   input  logic [31:0]          base_addr_i,
   input  logic [31:0]          stride_i,
   input  logic [TRANS_CNT-1:0] tot_len_i,
   hci_core_sink_aligner_stream_if.slave stream,
   hci_core_sink_aligner_tcdm_if.master  tcdm,
   output logic                 ready_start_o,
   output logic                 done_o,
   output logic [TRANS_CNT-1:0] beat_cnt_o
);

   localparam int unsigned BE_W = DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      IDLE,
      WORKING,
      DONE
   } state_e;

   state_e               state_q, state_d;
   logic [31:0]          addr_q, addr_d;
   logic [31:0]          stride_q, stride_d;
   logic [TRANS_CNT-1:0] len_q, len_d;
   logic [TRANS_CNT-1:0] beat_cnt_q, beat_cnt_d;
   logic                 req_q, req_d;
   logic [31:0]          add_q, add_d;
   logic [BE_W-1:0]      be_q, be_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                 done_q, done_d;

   logic                 stream_ready;
   logic                 accept;
   logic                 req_free;
   logic [1:0]           off;
   logic                 unused_slack;

   // The register can take a new beat when empty or when its current beat retires now.
   assign req_free     = ~req_q | tcdm.gnt;
   assign stream_ready = enable_i & (state_q == WORKING) & (beat_cnt_q < len_q) & req_free;
   assign accept       = stream.valid & stream_ready;
   assign off          = addr_q[1:0];
   assign unused_slack = ^{stream.data[DATA_WIDTH-1:DATA_WIDTH-32], stream.strb[BE_W-1:BE_W-4]};

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      stride_d   = stride_q;
      len_d      = len_q;
      beat_cnt_d = beat_cnt_q;
      req_d      = req_q;
      add_d      = add_q;
      be_d       = be_q;
      data_d     = data_q;
      done_d     = 1'b0;

      // Retirement on gnt is independent of enable_i so a pending write never stalls.
      if (accept) begin
         req_d  = 1'b1;
         add_d  = {addr_q[31:2], 2'b00};
         be_d   = BE_W'(stream.strb[BE_W-5:0]) << off;
         data_d = DATA_WIDTH'(stream.data[DATA_WIDTH-33:0]) << {off, 3'b000};
      end else if (req_q && tcdm.gnt) begin
         req_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (start_i && enable_i) begin
               addr_d     = base_addr_i;
               stride_d   = stride_i;
               len_d      = tot_len_i;
               beat_cnt_d = '0;
               state_d    = (tot_len_i == '0) ? DONE : WORKING;
            end
         end
         WORKING: begin
            if (accept) begin
               addr_d     = addr_q + stride_q;
               beat_cnt_d = beat_cnt_q + TRANS_CNT'(1);
               if (beat_cnt_q + TRANS_CNT'(1) == len_q) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (enable_i && req_free) begin
               done_d     = 1'b1;
               beat_cnt_d = '0;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         stride_q   <= '0;
         len_q      <= '0;
         beat_cnt_q <= '0;
         req_q      <= 1'b0;
         add_q      <= '0;
         be_q       <= '0;
         data_q     <= '0;
         done_q     <= 1'b0;
      end else if (clear_i) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         stride_q   <= '0;
         len_q      <= '0;
         beat_cnt_q <= '0;
         req_q      <= 1'b0;
         add_q      <= '0;
         be_q       <= '0;
         data_q     <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         stride_q   <= stride_d;
         len_q      <= len_d;
         beat_cnt_q <= beat_cnt_d;
         req_q      <= req_d;
         add_q      <= add_d;
         be_q       <= be_d;
         data_q     <= data_d;
         done_q     <= done_d;
      end
   end

   assign stream.ready  = stream_ready;
   assign tcdm.req      = req_q;
   assign tcdm.add      = add_q;
   assign tcdm.wen      = 1'b0;
   assign tcdm.be       = be_q;
   assign tcdm.data     = data_q;
   assign ready_start_o = (state_q == IDLE);
   assign done_o        = done_q;
   assign beat_cnt_o    = beat_cnt_q;

endmodule

// File: tb/tb_hci_core_sink_aligner.sv
// Self-checking bench for hci_core_sink_aligner: randomized stream/grant/enable traffic
// checked against an address-arithmetic model of the expected TCDM write sequence.

module tb_hci_core_sink_aligner;

   localparam int unsigned DW = 64;
   localparam int unsigned TC = 16;
   localparam int unsigned BW = DW / 8;
   localparam logic [DW-1:0] PAY_MASK = {32'h0, {(DW-32){1'b1}}};

   logic          clk = 1'b0;
   logic          rst_ni = 1'b0;
   logic          clear_i = 1'b0;
   logic          enable_i = 1'b0;
   logic          start_i = 1'b0;
   logic [31:0]   base_addr_i = '0;
   logic [31:0]   stride_i = '0;
   logic [TC-1:0] tot_len_i = '0;
   logic          ready_start_o;
   logic          done_o;
   logic [TC-1:0] beat_cnt_o;

   hci_core_sink_aligner_stream_if #(.DATA_WIDTH(DW)) stream_if ();
   hci_core_sink_aligner_tcdm_if   #(.DATA_WIDTH(DW)) tcdm_if ();

   hci_core_sink_aligner #(
      .DATA_WIDTH (DW),
      .TRANS_CNT  (TC)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .clear_i       (clear_i),
      .enable_i      (enable_i),
      .start_i       (start_i),
      .base_addr_i   (base_addr_i),
      .stride_i      (stride_i),
      .tot_len_i     (tot_len_i),
      .stream        (stream_if),
      .tcdm          (tcdm_if),
      .ready_start_o (ready_start_o),
      .done_o        (done_o),
      .beat_cnt_o    (beat_cnt_o)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_fail = 0;

   logic [DW-1:0] beat_data[$];
   logic [BW-1:0] beat_strb[$];
   logic [31:0]   obs_add[$];
   logic [BW-1:0] obs_be[$];
   logic [DW-1:0] obs_data[$];
   int unsigned   obs_cyc[$];
   int unsigned   stall_from = 0;
   int unsigned   stall_len = 0;

   // Payload is the low DW-32 bits, moved up by the byte offset of the address.
   function automatic logic [DW-1:0] model_data(input logic [DW-1:0] d, input logic [31:0] a);
      return (d & PAY_MASK) * (DW'(1) << (8 * a[1:0]));
   endfunction

   function automatic logic [BW-1:0] model_be(input logic [BW-1:0] s, input logic [31:0] a);
      return BW'(32'(s[3:0]) * (32'd1 << a[1:0]));
   endfunction

   task automatic run_transfer(input logic [31:0] base, input logic [31:0] stride,
                               input int unsigned len, input int unsigned v_pct,
                               input int unsigned g_pct, input int unsigned e_pct,
                               output int unsigned done_cyc);
      logic [31:0]   q_add[$];
      logic [BW-1:0] q_be[$];
      logic [DW-1:0] q_data[$];
      logic [31:0]   hold_add = '0;
      logic [BW-1:0] hold_be = '0;
      logic [DW-1:0] hold_data = '0;
      logic [31:0]   a;
      int unsigned   sent = 0, retired = 0, cyc = 0, sent_before, budget;
      bit acc_prev = 0, pend_prev = 0, exit_prev = 0, exited = 0, finished = 0;
      bit m_req, exp_ready, exp_done, exp_rs, acc, en, g, exit_now;
      obs_add.delete(); obs_be.delete(); obs_data.delete(); obs_cyc.delete();
      while (beat_data.size() < len) begin
         beat_data.push_back({$urandom, $urandom});
         beat_strb.push_back(BW'($urandom));
      end
      budget = 60 * len + 60;
      done_cyc = 0;
      while (!finished) begin
         @(negedge clk);
         en = (cyc == 0) || ($urandom_range(0, 99) < e_pct);
         g  = ($urandom_range(0, 99) < g_pct) && !(cyc >= stall_from && cyc < stall_from + stall_len);
         if (cyc == 0) begin
            start_i = 1'b1; base_addr_i = base; stride_i = stride; tot_len_i = TC'(len);
         end else begin
            // start pulses while busy must be ignored
            start_i = (retired < len) && ($urandom_range(0, 3) == 0);
            base_addr_i = $urandom; stride_i = $urandom; tot_len_i = TC'($urandom);
         end
         enable_i = en;
         tcdm_if.gnt = g;
         stream_if.valid = (sent < len) && ($urandom_range(0, 99) < v_pct);
         if (stream_if.valid) begin
            stream_if.data = beat_data[sent]; stream_if.strb = beat_strb[sent];
         end else begin
            stream_if.data = {$urandom, $urandom}; stream_if.strb = BW'($urandom);
         end
         #2;
         sent_before = sent;
         m_req     = acc_prev || pend_prev;
         exp_ready = (cyc > 0) && en && (sent < len) && (!m_req || g);
         exp_done  = exit_prev;
         exp_rs    = (cyc == 0) || exp_done;
         n_checks++;
         if (tcdm_if.req !== m_req) begin
            n_fail++; $display("FAIL req c%0d: got %b want %b", cyc, tcdm_if.req, m_req);
         end
         n_checks++;
         if (stream_if.ready !== exp_ready) begin
            n_fail++; $display("FAIL ready c%0d: got %b want %b", cyc, stream_if.ready, exp_ready);
         end
         n_checks++;
         if (done_o !== exp_done) begin
            n_fail++; $display("FAIL done c%0d: got %b want %b", cyc, done_o, exp_done);
         end
         n_checks++;
         if (ready_start_o !== exp_rs) begin
            n_fail++; $display("FAIL ready_start c%0d: got %b want %b", cyc, ready_start_o, exp_rs);
         end
         n_checks++;
         if (beat_cnt_o !== (exp_done ? TC'(0) : TC'(sent_before))) begin
            n_fail++; $display("FAIL beat_cnt c%0d: got %0d want %0d", cyc, beat_cnt_o, exp_done ? 0 : sent_before);
         end
         if (pend_prev) begin
            n_checks++;
            if ({tcdm_if.add, tcdm_if.be, tcdm_if.data} !== {hold_add, hold_be, hold_data}) begin
               n_fail++; $display("FAIL stable c%0d: got %h/%h/%h want %h/%h/%h", cyc,
                  tcdm_if.add, tcdm_if.be, tcdm_if.data, hold_add, hold_be, hold_data);
            end
         end
         acc = stream_if.valid && stream_if.ready;
         if (acc) begin
            a = base + sent * stride;
            q_add.push_back(a & 32'hFFFF_FFFC);
            q_be.push_back(model_be(stream_if.strb, a));
            q_data.push_back(model_data(stream_if.data, a));
            sent++;
         end
         if (tcdm_if.req && g) begin
            n_checks++;
            if (q_add.size() == 0) begin
               n_fail++; $display("FAIL write c%0d: got add %h want no write", cyc, tcdm_if.add);
            end else begin
               if ({tcdm_if.add, tcdm_if.be, tcdm_if.data} !== {q_add[0], q_be[0], q_data[0]}) begin
                  n_fail++; $display("FAIL write c%0d: got %h/%h/%h want %h/%h/%h", cyc,
                     tcdm_if.add, tcdm_if.be, tcdm_if.data, q_add[0], q_be[0], q_data[0]);
               end
               void'(q_add.pop_front()); void'(q_be.pop_front()); void'(q_data.pop_front());
            end
            obs_add.push_back(tcdm_if.add); obs_be.push_back(tcdm_if.be);
            obs_data.push_back(tcdm_if.data); obs_cyc.push_back(cyc);
            retired++;
         end
         exit_now = (cyc > 0) && (sent_before == len) && !exited && en && (!m_req || g);
         if (exit_now) exited = 1;
         if (exp_done) begin
            finished = 1;
            done_cyc = cyc;
            n_checks++;
            if (retired != len || q_add.size() != 0) begin
               n_fail++; $display("FAIL completion: got %0d writes want %0d", retired, len);
            end
         end
         acc_prev  = acc;
         pend_prev = m_req && !g;
         hold_add = tcdm_if.add; hold_be = tcdm_if.be; hold_data = tcdm_if.data;
         exit_prev = exit_now;
         cyc++;
         if (!finished && cyc > budget) begin
            n_checks++; n_fail++;
            $display("FAIL timeout: got no done after %0d cycles want done", cyc);
            finished = 1;
         end
      end
      start_i = 1'b0;
      stream_if.valid = 1'b0;
      beat_data.delete(); beat_strb.delete();
   endtask

   task automatic test_reset();
      enable_i = 1'b1; stream_if.valid = 1'b0; tcdm_if.gnt = 1'b0;
      stream_if.data = '0; stream_if.strb = '0;
      repeat (2) @(negedge clk);
      #2;
      n_checks++;
      if ({tcdm_if.req, stream_if.ready, done_o, tcdm_if.wen} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {tcdm_if.req, stream_if.ready, done_o, tcdm_if.wen});
      end
      n_checks++;
      if (ready_start_o !== 1'b1 || beat_cnt_o !== '0) begin
         n_fail++; $display("FAIL reset_status: got rs=%b cnt=%0d want rs=1 cnt=0", ready_start_o, beat_cnt_o);
      end
      n_checks++;
      if ({tcdm_if.add, tcdm_if.be, tcdm_if.data} !== '0) begin
         n_fail++; $display("FAIL reset_payload: got %h/%h/%h want 0", tcdm_if.add, tcdm_if.be, tcdm_if.data);
      end
      @(negedge clk);
      rst_ni = 1'b1;
   endtask

   task automatic test_basic();
      int unsigned dc;
      for (int unsigned i = 0; i < 4; i++) begin
         beat_data.push_back(DW'(i)); beat_strb.push_back(8'hFF);
      end
      run_transfer(32'h100, 32'd8, 4, 100, 100, 100, dc);
      n_checks++;
      if (dc != 6) begin
         n_fail++; $display("FAIL basic_done_cycle: got %0d want 6", dc);
      end
      for (int unsigned i = 0; i < 4; i++) begin
         n_checks++;
         if (obs_add.size() <= i) begin
            n_fail++; $display("FAIL basic_write%0d: got missing want present", i);
         end else if (obs_add[i] !== 32'h100 + 8 * i || obs_be[i] !== 8'h0F || obs_cyc[i] != i + 2) begin
            n_fail++; $display("FAIL basic_write%0d: got %h/%h@%0d want %h/0f@%0d", i,
               obs_add[i], obs_be[i], obs_cyc[i], 32'h100 + 8 * i, i + 2);
         end
      end
   endtask

   task automatic test_misaligned();
      int unsigned dc;
      beat_data.push_back(64'hDEADBEEF_AABBCCDD); beat_strb.push_back(8'hFF);
      run_transfer(32'h203, 32'd4, 1, 100, 100, 100, dc);
      n_checks++;
      if (obs_add.size() != 1) begin
         n_fail++; $display("FAIL misaligned_count: got %0d want 1", obs_add.size());
      end else if (obs_add[0] !== 32'h200 || obs_be[0] !== 8'h78 || obs_data[0] !== 64'h00AABBCC_DD000000) begin
         n_fail++; $display("FAIL misaligned: got %h/%h/%h want 00000200/78/00aabbccdd000000",
            obs_add[0], obs_be[0], obs_data[0]);
      end
   endtask

   task automatic test_stall();
      int unsigned dc;
      stall_from = 3; stall_len = 3;
      run_transfer(32'h40, 32'd4, 6, 100, 100, 100, dc);
      stall_from = 0; stall_len = 0;
      n_checks++;
      if (dc != 11 || obs_add.size() != 6) begin
         n_fail++; $display("FAIL stall: got done@%0d writes=%0d want done@11 writes=6", dc, obs_add.size());
      end
   endtask

   task automatic test_zero_len();
      int unsigned dc;
      run_transfer(32'h80, 32'd4, 0, 100, 100, 100, dc);
      n_checks++;
      if (dc != 2 || obs_add.size() != 0) begin
         n_fail++; $display("FAIL zero_len: got done@%0d writes=%0d want done@2 writes=0", dc, obs_add.size());
      end
   endtask

   task automatic test_enable();
      int unsigned dc;
      for (int unsigned k = 0; k < 3; k++) begin
         run_transfer($urandom, 32'd12, 8, 90, 50, 40, dc);
      end
   endtask

   task automatic test_wrap();
      int unsigned dc;
      run_transfer(32'hFFFF_FFF8, 32'd8, 2, 100, 100, 100, dc);
      n_checks++;
      if (obs_add.size() != 2) begin
         n_fail++; $display("FAIL wrap_count: got %0d want 2", obs_add.size());
      end else if (obs_add[0] !== 32'hFFFF_FFF8 || obs_add[1] !== 32'h0) begin
         n_fail++; $display("FAIL wrap: got %h,%h want fffffff8,00000000", obs_add[0], obs_add[1]);
      end
   endtask

   task automatic test_clear();
      @(negedge clk);
      start_i = 1'b1; base_addr_i = 32'h1000; stride_i = 32'd4; tot_len_i = TC'(8);
      enable_i = 1'b1; tcdm_if.gnt = 1'b0;
      stream_if.valid = 1'b1; stream_if.data = {$urandom, $urandom}; stream_if.strb = 8'hFF;
      @(negedge clk);
      start_i = 1'b0;
      @(negedge clk);
      #2;
      n_checks++;
      if (tcdm_if.req !== 1'b1 || stream_if.ready !== 1'b0) begin
         n_fail++; $display("FAIL clear_pre: got req=%b ready=%b want req=1 ready=0", tcdm_if.req, stream_if.ready);
      end
      @(negedge clk);
      clear_i = 1'b1;
      @(negedge clk);
      clear_i = 1'b0; stream_if.valid = 1'b0;
      #2;
      n_checks++;
      if ({tcdm_if.req, stream_if.ready, done_o, ready_start_o} !== 4'b0001 || beat_cnt_o !== '0 || tcdm_if.add !== '0) begin
         n_fail++; $display("FAIL clear_post: got req=%b rdy=%b done=%b rs=%b cnt=%0d add=%h want 0,0,0,1,0,0",
            tcdm_if.req, stream_if.ready, done_o, ready_start_o, beat_cnt_o, tcdm_if.add);
      end
   endtask

   task automatic test_random();
      int unsigned dc;
      for (int unsigned k = 0; k < 8; k++) begin
         run_transfer($urandom, (k % 2 == 0) ? 32'($urandom_range(0, 15)) : $urandom,
                      $urandom_range(1, 16), $urandom_range(30, 100),
                      $urandom_range(30, 100), $urandom_range(50, 100), dc);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_misaligned();
      test_stall();
      test_zero_len();
      test_enable();
      test_wrap();
      test_clear();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got simulation still running want finished");
      $fatal(1, "watchdog expired");
   end

endmodule
